reg_pipe_chain: RTL and testbench
=================================

REG_PIPE_CHAIN -- requirements
Module: reg_pipe_chain

Interface
REQ-001: Parameter WIDTH, default 18, data width in bits (1..48).
REQ-002: Parameter DEPTH, default 2, number of register stages (0..8); 0 = pure combinational bypass.
REQ-003: Parameter RST_VAL, default 0, WIDTH-bit value loaded into every data stage on reset or flush.
REQ-004: clk  input  1  single clock, rising-edge active.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: clk_en  input  1  advance enable; when 0, all stages hold.
REQ-007: flush  input  1  synchronous clear of all stages.
REQ-008: in_valid  input  1  qualifier for in.
REQ-009: in  input  WIDTH  data entering stage 1.
REQ-010: tap_sel  input  4  selects the stage driven on out_tap.
REQ-011: out_valid  output  1  valid qualifier of the last stage.
REQ-012: out  output  WIDTH  data of the last stage.
REQ-013: out_tap  output  WIDTH  data of the stage chosen by tap_sel.
REQ-014: tap_valid  output  1  valid qualifier of the stage chosen by tap_sel.
REQ-015: occupancy  output  4  count of stages currently holding valid data (0..DEPTH).

Function
REQ-016: Stages SHALL be numbered 1..DEPTH; stage 0 denotes the live in/in_valid pair.
REQ-017: On a rising clk with clk_en=1 and flush=0: stage1 <= in and in_valid; stage k <= stage k-1 for k = 2..DEPTH; data and valid move together.
REQ-018: With clk_en=0 and flush=0, all data and valid bits SHALL hold, regardless of in_valid.
REQ-019: flush=1 at a rising clk SHALL load RST_VAL into every data stage and clear every valid bit, irrespective of clk_en; flush has priority over advance.
REQ-020: Data SHALL advance whether or not in_valid=1; invalid entries are bubbles that still shift (no compaction).
REQ-021: out/out_valid SHALL be stage DEPTH, giving a latency of exactly DEPTH enabled cycles from in to out.
REQ-022: DEPTH=0: out=in, out_valid=in_valid combinationally, occupancy=0, and clk_en/flush have no effect.
REQ-023: out_tap/tap_valid SHALL combinationally reflect stage tap_sel; tap_sel=0 gives in/in_valid.
REQ-024: tap_sel > DEPTH SHALL saturate to stage DEPTH (same as out/out_valid).
REQ-025: occupancy SHALL be a registered count equal to the number of set valid bits after each edge, computed from the next-state valids: on advance it increments by in_valid minus the valid bit shifted out of stage DEPTH, and on flush it returns to 0.
REQ-026: occupancy SHALL never exceed DEPTH; simultaneous entry and exit leave it unchanged.
REQ-027: All outputs SHALL be glitch-free functions of registers, except the out_tap/tap_valid path for tap_sel=0 and the DEPTH=0 path.

Reset
REQ-028: rst=1 SHALL immediately (without clk) force every data stage to RST_VAL, every valid bit to 0, and occupancy to 0.
REQ-029: While rst=1, clk_en, flush and in_valid SHALL be ignored; the first advance occurs on the first rising clk after rst deasserts.
REQ-030: Reset asserted mid-stream SHALL discard all in-flight entries; no partial stage contents survive.

Verification
REQ-031: DEPTH=3, clk_en=1, in=0x00011,0x00022,0x00033 each with in_valid=1 on consecutive cycles -> out=0x00011 with out_valid=1 on the 3rd edge after entry, occupancy reaches 3 and stays 3 while the stream continues.
REQ-032: DEPTH=3, stream running, clk_en=0 for 4 cycles -> out, out_tap, and occupancy frozen; resume -> sequence continues with no loss or duplication.
REQ-033: DEPTH=3, three valid entries in flight, flush=1 with clk_en=0 for 1 cycle -> all valids 0, out=RST_VAL, occupancy=0 after that edge.
REQ-034: DEPTH=4, valid/bubble/valid pattern in -> occupancy 1,1,2 after the three edges; tap_sel=2 shows the bubble with tap_valid=0 after the 3rd edge; tap_sel=9 equals out.
REQ-035: rst pulsed asynchronously between clk edges with occupancy=2 -> out=RST_VAL, out_valid=0, occupancy=0 before the next edge.
REQ-036: DEPTH=0, in toggled 0x3FFFF/0x00000 -> out follows in within the same cycle, occupancy=0 throughout.

Source files
------------

// File: rtl/reg_pipe_chain.sv
// rtl/reg_pipe_chain.sv - parameterised register pipeline with valid tracking, tap mux and occupancy
module reg_pipe_chain #(
  parameter int               WIDTH   = 18,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [3:0]       tap_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_tap,
  output logic             tap_valid,
  output logic [3:0]       occupancy
);

  if (DEPTH == 0) begin : g_bypass
    // No storage: every control input is irrelevant on this path.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, clk_en, flush, tap_sel};

    assign out       = in;
    assign out_valid = in_valid;
    assign out_tap   = in;
    assign tap_valid = in_valid;
    assign occupancy = 4'd0;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q [1:DEPTH];
    logic [DEPTH:1]   valid_q;
    logic [3:0]       occ_q;
    logic [3:0]       sel;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 1; k <= DEPTH; k++) data_q[k] <= RST_VAL;
        valid_q <= '0;
        occ_q   <= 4'd0;
      end else if (flush) begin
        for (int k = 1; k <= DEPTH; k++) data_q[k] <= RST_VAL;
        valid_q <= '0;
        occ_q   <= 4'd0;
      end else if (clk_en) begin
        data_q[1]  <= in;
        valid_q[1] <= in_valid;
        for (int k = 2; k <= DEPTH; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
        // Entry and exit in the same cycle cancel, so the count stays within 0..DEPTH.
        occ_q <= occ_q + {3'b000, in_valid} - {3'b000, valid_q[DEPTH]};
      end
    end

    assign sel = (tap_sel > 4'(DEPTH)) ? 4'(DEPTH) : tap_sel;

    always_comb begin
      out_tap   = in;
      tap_valid = in_valid;
      for (int k = 1; k <= DEPTH; k++) begin
        if (sel == 4'(k)) begin
          out_tap   = data_q[k];
          tap_valid = valid_q[k];
        end
      end
    end

    assign out       = data_q[DEPTH];
    assign out_valid = valid_q[DEPTH];
    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_reg_pipe_chain.sv
// tb/tb_reg_pipe_chain.sv - self-checking bench for reg_pipe_chain at DEPTH 3, 4 and 0
module tb_reg_pipe_chain;
  localparam int W = 18;
  localparam logic [W-1:0] RV3 = 18'h15A5A;
  localparam logic [W-1:0] RV4 = 18'h00000;

  logic         clk = 1'b0;
  logic         rst, clk_en, flush, in_valid;
  logic [W-1:0] in_data;
  logic [3:0]   tap_sel;

  logic         ov3, tv3, ov4, tv4, ov0, tv0;
  logic [W-1:0] out3, tap3, out4, tap4, out0, tap0;
  logic [3:0]   occ3, occ4, occ0;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] last_out;

  always #5 clk = ~clk;

  reg_pipe_chain #(.WIDTH(W), .DEPTH(3), .RST_VAL(RV3)) dut3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .in_valid(in_valid),
    .in(in_data), .tap_sel(tap_sel), .out_valid(ov3), .out(out3),
    .out_tap(tap3), .tap_valid(tv3), .occupancy(occ3));

  reg_pipe_chain #(.WIDTH(W), .DEPTH(4), .RST_VAL(RV4)) dut4 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .in_valid(in_valid),
    .in(in_data), .tap_sel(tap_sel), .out_valid(ov4), .out(out4),
    .out_tap(tap4), .tap_valid(tv4), .occupancy(occ4));

  reg_pipe_chain #(.WIDTH(W), .DEPTH(0), .RST_VAL(RV4)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .in_valid(in_valid),
    .in(in_data), .tap_sel(tap_sel), .out_valid(ov0), .out(out0),
    .out_tap(tap0), .tap_valid(tv0), .occupancy(occ0));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_data = 18'h3FFFF; tap_sel = 4'd1;
    #1;
    checks++; if (out3 !== RV3) begin failures++; $display("FAIL reset_out3 got=%h exp=%h", out3, RV3); end
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL reset_ov3 got=%b exp=0", ov3); end
    checks++; if (occ3 !== 4'd0) begin failures++; $display("FAIL reset_occ3 got=%0d exp=0", occ3); end
    checks++; if (tap3 !== RV3 || tv3 !== 1'b0) begin failures++; $display("FAIL reset_tap3 got=%h/%b exp=%h/0", tap3, tv3, RV3); end
    checks++; if (out4 !== RV4 || occ4 !== 4'd0) begin failures++; $display("FAIL reset_d4 got=%h/%0d exp=%h/0", out4, occ4, RV4); end
    step; step;
    checks++; if (occ3 !== 4'd0 || tv3 !== 1'b0) begin failures++; $display("FAIL reset_held got=%0d/%b exp=0/0", occ3, tv3); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stream;
    logic [W-1:0] exp;
    clk_en = 1'b1;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      in_data = W'(18'h11 * (i + 1)); in_valid = 1'b1;
      sb.push_back(in_data);
      step;
      checks++; if (occ3 !== 4'((i + 1 > 3) ? 3 : i + 1)) begin failures++; $display("FAIL stream_occ i=%0d got=%0d", i, occ3); end
      checks++; if (ov3 !== (i >= 2)) begin failures++; $display("FAIL stream_ov i=%0d got=%b exp=%b", i, ov3, (i >= 2)); end
      if (i >= 2) begin
        exp = sb.pop_front();
        last_out = exp;
        checks++; if (out3 !== exp) begin failures++; $display("FAIL stream_out i=%0d got=%h exp=%h", i, out3, exp); end
      end
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] exp;
    tap_sel = 4'd1; clk_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_data = W'(18'h3000 + c); in_valid = 1'b1;
      step;
      checks++; if (out3 !== last_out || ov3 !== 1'b1) begin failures++; $display("FAIL stall_out c=%0d got=%h exp=%h", c, out3, last_out); end
      checks++; if (tap3 !== sb[sb.size()-1]) begin failures++; $display("FAIL stall_tap c=%0d got=%h exp=%h", c, tap3, sb[sb.size()-1]); end
      checks++; if (occ3 !== 4'd3) begin failures++; $display("FAIL stall_occ c=%0d got=%0d exp=3", c, occ3); end
    end
    clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(18'h100 + i); in_valid = 1'b1;
      sb.push_back(in_data);
      step;
      exp = sb.pop_front();
      checks++; if (out3 !== exp || ov3 !== 1'b1) begin failures++; $display("FAIL resume_out i=%0d got=%h exp=%h", i, out3, exp); end
      checks++; if (occ3 !== 4'd3) begin failures++; $display("FAIL resume_occ i=%0d got=%0d exp=3", i, occ3); end
    end
  endtask

  task automatic test_flush;
    clk_en = 1'b0; flush = 1'b1; in_valid = 1'b1;
    step;
    flush = 1'b0; tap_sel = 4'd2;
    #1;
    checks++; if (ov3 !== 1'b0 || out3 !== RV3) begin failures++; $display("FAIL flush_out got=%h/%b exp=%h/0", out3, ov3, RV3); end
    checks++; if (occ3 !== 4'd0 || occ4 !== 4'd0) begin failures++; $display("FAIL flush_occ got=%0d/%0d exp=0/0", occ3, occ4); end
    checks++; if (tv3 !== 1'b0 || tap3 !== RV3) begin failures++; $display("FAIL flush_tap got=%h/%b exp=%h/0", tap3, tv3, RV3); end
    sb.delete();
  endtask

  task automatic test_bubbles;
    clk_en = 1'b1;
    in_valid = 1'b1; in_data = 18'h0A0A; step;
    checks++; if (occ4 !== 4'd1) begin failures++; $display("FAIL bub_occ1 got=%0d exp=1", occ4); end
    in_valid = 1'b0; in_data = 18'h0B0B; step;
    checks++; if (occ4 !== 4'd1) begin failures++; $display("FAIL bub_occ2 got=%0d exp=1", occ4); end
    in_valid = 1'b1; in_data = 18'h0C0C; step;
    checks++; if (occ4 !== 4'd2) begin failures++; $display("FAIL bub_occ3 got=%0d exp=2", occ4); end
    tap_sel = 4'd2; #1;
    checks++; if (tv4 !== 1'b0 || tap4 !== 18'h0B0B) begin failures++; $display("FAIL bub_tap2 got=%h/%b exp=0b0b/0", tap4, tv4); end
    tap_sel = 4'd3; #1;
    checks++; if (tv4 !== 1'b1 || tap4 !== 18'h0A0A) begin failures++; $display("FAIL bub_tap3 got=%h/%b exp=0a0a/1", tap4, tv4); end
    tap_sel = 4'd9; #1;
    checks++; if (tv4 !== 1'b0 || tap4 !== RV4) begin failures++; $display("FAIL bub_tap9a got=%h/%b exp=%h/0", tap4, tv4, RV4); end
    in_valid = 1'b0; in_data = 18'h0D0D; step;
    checks++; if (tv4 !== 1'b1 || tap4 !== 18'h0A0A || out4 !== 18'h0A0A || ov4 !== 1'b1) begin
      failures++; $display("FAIL bub_tap9b got=%h/%b out=%h/%b exp=0a0a/1", tap4, tv4, out4, ov4); end
    checks++; if (occ4 !== 4'd2) begin failures++; $display("FAIL bub_occ4 got=%0d exp=2", occ4); end
    tap_sel = 4'd0; #1;
    checks++; if (tap4 !== 18'h0D0D || tv4 !== 1'b0) begin failures++; $display("FAIL bub_tap0 got=%h/%b exp=0d0d/0", tap4, tv4); end
  endtask

  task automatic test_async_reset;
    flush = 1'b1; step; flush = 1'b0;
    clk_en = 1'b1; in_valid = 1'b1;
    in_data = 18'h1111; step;
    in_data = 18'h2222; step;
    in_valid = 1'b0;
    checks++; if (occ3 !== 4'd2) begin failures++; $display("FAIL arst_pre_occ got=%0d exp=2", occ3); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out3 !== RV3 || ov3 !== 1'b0) begin failures++; $display("FAIL arst_out got=%h/%b exp=%h/0", out3, ov3, RV3); end
    checks++; if (occ3 !== 4'd0 || occ4 !== 4'd0) begin failures++; $display("FAIL arst_occ got=%0d/%0d exp=0/0", occ3, occ4); end
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 18'h3333; tap_sel = 4'd1;
    step;
    in_valid = 1'b0;
    checks++; if (occ3 !== 4'd1 || tap3 !== 18'h3333 || tv3 !== 1'b1) begin
      failures++; $display("FAIL arst_first got=%0d/%h/%b exp=1/3333/1", occ3, tap3, tv3); end
    tap_sel = 4'd2; #1;
    checks++; if (tap3 !== RV3 || tv3 !== 1'b0 || out3 !== RV3) begin
      failures++; $display("FAIL arst_clean got=%h/%b out=%h exp=%h/0", tap3, tv3, out3, RV3); end
  endtask

  task automatic test_bypass;
    for (int i = 0; i < 6; i++) begin
      in_data  = (i % 2 == 0) ? 18'h3FFFF : 18'h00000;
      in_valid = (i % 3 != 2);
      clk_en   = (i % 2 == 1);
      flush    = (i == 3);
      tap_sel  = 4'(i * 2);
      #1;
      checks++; if (out0 !== in_data || ov0 !== in_valid) begin failures++; $display("FAIL byp_out i=%0d got=%h/%b exp=%h/%b", i, out0, ov0, in_data, in_valid); end
      checks++; if (tap0 !== in_data || tv0 !== in_valid) begin failures++; $display("FAIL byp_tap i=%0d got=%h/%b", i, tap0, tv0); end
      step;
      checks++; if (occ0 !== 4'd0 || out0 !== in_data) begin failures++; $display("FAIL byp_occ i=%0d got=%0d/%h exp=0/%h", i, occ0, out0, in_data); end
    end
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_flush;
    test_bubbles;
    test_async_reset;
    test_bypass;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
